// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - ExceptioNull CPU shared opcodes, field slices and constants
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int MEM_AW = 8;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD = 4'h0;
  localparam opcode_t OP_SUB = 4'h1;
  localparam opcode_t OP_AND = 4'h2;
  localparam opcode_t OP_OR  = 4'h3;
  localparam opcode_t OP_XOR = 4'h4;
  localparam opcode_t OP_NOR = 4'h5;
  localparam opcode_t OP_SLL = 4'h6;
  localparam opcode_t OP_SRL = 4'h7;
  localparam opcode_t OP_SLT = 4'h8;
  localparam opcode_t OP_LW  = 4'h9;
  localparam opcode_t OP_SW  = 4'hA;
  localparam opcode_t OP_J   = 4'hB;
  localparam opcode_t OP_BEQ = 4'hC;
  localparam opcode_t OP_BNE = 4'hD;
  localparam opcode_t OP_JAL = 4'hE;
  localparam opcode_t OP_NOP = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RA_MSB  = 3;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;

  localparam logic [1:0] JAL_RD = 2'd3;

endpackage

// File: rtl/exec_stage_if.sv
// rtl/exec_stage_if.sv - issue/register-file/writeback bundle of the execute stage
interface exec_stage_if;
  logic       instr_valid;
  logic [7:0] instruction;
  logic [7:0] pc;
  logic [7:0] reg_data_0;
  logic [7:0] reg_data_1;
  logic [1:0] reg_addr_0;
  logic [1:0] reg_addr_1;
  logic [1:0] reg_addr_w;
  logic       reg_w_en;
  logic [7:0] reg_w_data;
  logic       jump;
  logic       overflow;
  logic       done;

  modport master (
    output instr_valid, instruction, pc, reg_data_0, reg_data_1,
    input  reg_addr_0, reg_addr_1, reg_addr_w, reg_w_en, reg_w_data,
           jump, overflow, done
  );

  modport slave (
    input  instr_valid, instruction, pc, reg_data_0, reg_data_1,
    output reg_addr_0, reg_addr_1, reg_addr_w, reg_w_en, reg_w_data,
           jump, overflow, done
  );
endinterface

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU: arithmetic/logic/shift/compare plus signed overflow
module exec_alu
  import cpu_pkg::*;
(
  input  opcode_t    op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] result_o,
  output logic       overflow_o
);

  logic [7:0] sum;
  logic [7:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
      end
      OP_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[7] != b_i[7]) && (diff[7] != a_i[7]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_SLL:  result_o = a_i << b_i[2:0];
      OP_SRL:  result_o = a_i >> b_i[2:0];
      OP_SLT:  result_o = {7'd0, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute/memory stage: decode, ALU, branch, data memory, registered writeback
module exec_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  exec_stage_if.slave  bus
);

  opcode_t    opcode;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] op_a;
  logic [7:0] op_b;

  assign opcode = bus.instruction[OPC_MSB:OPC_LSB];
  assign ra     = bus.instruction[RA_MSB:RA_LSB];
  assign rb     = bus.instruction[RB_MSB:RB_LSB];
  assign op_a   = bus.reg_data_0;
  assign op_b   = bus.reg_data_1;

  assign bus.reg_addr_0 = ra;
  assign bus.reg_addr_1 = rb;

  logic [7:0] alu_result;
  logic       alu_overflow;

  exec_alu u_alu (
    .op_i       (opcode),
    .a_i        (op_a),
    .b_i        (op_b),
    .result_o   (alu_result),
    .overflow_o (alu_overflow)
  );

  // Not reset: contents must survive rst_n, and stores are gated by rst_n at the edge.
  logic [7:0] mem [0:(1 << MEM_AW) - 1];

  always_ff @(posedge clk) begin
    if (rst_n && bus.instr_valid && (opcode == OP_SW)) begin
      mem[op_b] <= op_a;
    end
  end

  logic [1:0] reg_addr_w_d, reg_addr_w_q;
  logic [7:0] reg_w_data_d, reg_w_data_q;
  logic       reg_w_en_d,   reg_w_en_q;
  logic       jump_d,       jump_q;
  logic       done_q;
  logic       overflow_q;

  always_comb begin
    reg_w_en_d   = 1'b1;
    jump_d       = 1'b0;
    reg_addr_w_d = ra;
    reg_w_data_d = alu_result;
    case (opcode)
      OP_LW:  reg_w_data_d = mem[op_b];
      OP_SW:  reg_w_en_d   = 1'b0;
      OP_J: begin
        reg_w_en_d = 1'b0;
        jump_d     = 1'b1;
      end
      OP_BEQ: begin
        reg_w_en_d = 1'b0;
        jump_d     = (op_a == op_b);
      end
      OP_BNE: begin
        reg_w_en_d = 1'b0;
        jump_d     = (op_a != op_b);
      end
      OP_JAL: begin
        jump_d       = 1'b1;
        reg_addr_w_d = JAL_RD;
        reg_w_data_d = bus.pc + 8'd1;
      end
      OP_NOP: reg_w_en_d = 1'b0;
      default: ;
    endcase
  end

  // Data and destination hold while idle; the pulse-like flags clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q       <= 1'b0;
      reg_w_en_q   <= 1'b0;
      jump_q       <= 1'b0;
      overflow_q   <= 1'b0;
      reg_addr_w_q <= '0;
      reg_w_data_q <= '0;
    end else if (bus.instr_valid) begin
      done_q       <= 1'b1;
      reg_w_en_q   <= reg_w_en_d;
      jump_q       <= jump_d;
      overflow_q   <= alu_overflow;
      reg_addr_w_q <= reg_addr_w_d;
      reg_w_data_q <= reg_w_data_d;
    end else begin
      done_q     <= 1'b0;
      reg_w_en_q <= 1'b0;
      jump_q     <= 1'b0;
      overflow_q <= 1'b0;
    end
  end

  assign bus.done       = done_q;
  assign bus.reg_w_en   = reg_w_en_q;
  assign bus.jump       = jump_q;
  assign bus.overflow   = overflow_q;
  assign bus.reg_addr_w = reg_addr_w_q;
  assign bus.reg_w_data = reg_w_data_q;

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - self-checking bench for exec_stage against a behavioural ISA model
module tb_exec_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  exec_stage_if bus ();

  exec_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs derived from the instruction-set rules.
  logic       m_done = 0, m_wen = 0, m_jump = 0, m_ovf = 0, m_known = 1;
  logic [1:0] m_addr = 0;
  logic [7:0] m_data = 0;
  logic [7:0] m_mem [int];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done = 0; m_wen = 0; m_jump = 0; m_ovf = 0;
      m_addr = 0; m_data = 0; m_known = 1;
    end else if (bus.instr_valid) begin
      logic [7:0] a, b;
      logic [3:0] op;
      int sa, sb, s;
      a  = bus.reg_data_0;
      b  = bus.reg_data_1;
      op = bus.instruction[7:4];
      sa = $signed(a);
      sb = $signed(b);
      m_done = 1; m_jump = 0; m_ovf = 0; m_wen = 1; m_known = 1;
      m_addr = bus.instruction[3:2];
      case (op)
        4'h0: begin s = sa + sb; m_data = 8'(s); m_ovf = (s > 127) || (s < -128); end
        4'h1: begin s = sa - sb; m_data = 8'(s); m_ovf = (s > 127) || (s < -128); end
        4'h2: m_data = a & b;
        4'h3: m_data = a | b;
        4'h4: m_data = a ^ b;
        4'h5: m_data = ~(a | b);
        4'h6: m_data = 8'(int'(a) * (1 << int'(b % 8)));
        4'h7: m_data = 8'(int'(a) / (1 << int'(b % 8)));
        4'h8: m_data = (sa < sb) ? 8'd1 : 8'd0;
        4'h9: if (m_mem.exists(int'(b))) m_data = m_mem[int'(b)]; else m_known = 0;
        4'hA: begin m_mem[int'(b)] = a; m_wen = 0; m_known = 0; end
        4'hB: begin m_jump = 1; m_wen = 0; m_known = 0; end
        4'hC: begin m_jump = (a == b); m_wen = 0; m_known = 0; end
        4'hD: begin m_jump = (a != b); m_wen = 0; m_known = 0; end
        4'hE: begin m_jump = 1; m_addr = 2'd3; m_data = 8'((int'(bus.pc) + 1) % 256); end
        default: begin m_wen = 0; m_known = 0; end
      endcase
    end else begin
      m_done = 0; m_wen = 0; m_jump = 0; m_ovf = 0;
    end
  end

  bit started = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("done",       {7'd0, bus.done},     {7'd0, m_done});
      chk("reg_w_en",   {7'd0, bus.reg_w_en}, {7'd0, m_wen});
      chk("jump",       {7'd0, bus.jump},     {7'd0, m_jump});
      chk("overflow",   {7'd0, bus.overflow}, {7'd0, m_ovf});
      chk("reg_addr_w", {6'd0, bus.reg_addr_w}, {6'd0, m_addr});
      chk("reg_addr_0", {6'd0, bus.reg_addr_0}, {6'd0, bus.instruction[3:2]});
      chk("reg_addr_1", {6'd0, bus.reg_addr_1}, {6'd0, bus.instruction[1:0]});
      if (m_known) chk("reg_w_data", bus.reg_w_data, m_data);
    end
  end

  task automatic issue(input logic [7:0] ins, input logic [7:0] p,
                       input logic [7:0] a, input logic [7:0] b);
    bus.instr_valid = 1'b1;
    bus.instruction = ins;
    bus.pc          = p;
    bus.reg_data_0  = a;
    bus.reg_data_1  = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instruction = 8'hF0;
    bus.pc          = 8'h00;
    bus.reg_data_0  = 8'h00;
    bus.reg_data_1  = 8'h00;
    repeat (3) @(negedge clk);
    started = 1;
    chk("rst done", {7'd0, bus.done}, 8'd0);
    chk("rst data", bus.reg_w_data, 8'h00);
    rst_n = 1'b1;

    issue(8'h06, 8'h00, 8'h7F, 8'h01);
    chk("add data", bus.reg_w_data, 8'h80);
    chk("add ovf",  {7'd0, bus.overflow}, 8'd1);
    chk("add wen",  {7'd0, bus.reg_w_en}, 8'd1);
    chk("add addr", {6'd0, bus.reg_addr_w}, 8'd1);
    chk("add done", {7'd0, bus.done}, 8'd1);

    issue(8'hA6, 8'h01, 8'h5A, 8'h10);
    chk("sw wen", {7'd0, bus.reg_w_en}, 8'd0);
    issue(8'h9E, 8'h02, 8'h00, 8'h10);
    chk("lw data", bus.reg_w_data, 8'h5A);
    chk("lw addr", {6'd0, bus.reg_addr_w}, 8'd3);

    issue(8'hC1, 8'h03, 8'h33, 8'h33);
    chk("beq eq", {7'd0, bus.jump}, 8'd1);
    issue(8'hD1, 8'h04, 8'h33, 8'h33);
    chk("bne eq", {7'd0, bus.jump}, 8'd0);
    issue(8'hD1, 8'h05, 8'h33, 8'h34);
    chk("bne ne", {7'd0, bus.jump}, 8'd1);

    issue(8'hE0, 8'hFF, 8'h12, 8'h34);
    chk("jal jump", {7'd0, bus.jump}, 8'd1);
    chk("jal wen",  {7'd0, bus.reg_w_en}, 8'd1);
    chk("jal addr", {6'd0, bus.reg_addr_w}, 8'd3);
    chk("jal data", bus.reg_w_data, 8'h00);

    issue(8'h11, 8'h06, 8'h00, 8'h01);
    chk("sub data", bus.reg_w_data, 8'hFF);
    chk("sub ovf",  {7'd0, bus.overflow}, 8'd0);
    issue(8'h64, 8'h07, 8'h81, 8'h09);
    chk("sll data", bus.reg_w_data, 8'h02);
    issue(8'h82, 8'h08, 8'h80, 8'h01);
    chk("slt data", bus.reg_w_data, 8'h01);

    idle();
    chk("idle done", {7'd0, bus.done}, 8'd0);
    chk("idle hold", bus.reg_w_data, 8'h01);

    issue(8'h11, 8'h09, 8'h80, 8'h01);
    chk("sub ovf data", bus.reg_w_data, 8'h7F);
    chk("sub ovf flag", {7'd0, bus.overflow}, 8'd1);

    for (int op = 0; op < 16; op++) begin
      logic [7:0] a, b;
      a = 8'(8'h3C + op * 7);
      b = (op == 9) ? 8'h10 : 8'(8'hC5 ^ op);
      issue({4'(op), 4'b1001}, 8'(op * 3), a, b);
      if (op % 5 == 4) idle();
    end

    issue(8'hA0, 8'h20, 8'h11, 8'h20);
    issue(8'h06, 8'h21, 8'h7F, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst done", {7'd0, bus.done},     8'd0);
    chk("async rst ovf",  {7'd0, bus.overflow}, 8'd0);
    chk("async rst wen",  {7'd0, bus.reg_w_en}, 8'd0);
    chk("async rst data", bus.reg_w_data, 8'h00);
    chk("async rst addr", {6'd0, bus.reg_addr_w}, 8'd0);
    bus.instr_valid = 1'b1;
    bus.instruction = 8'hA0;
    bus.reg_data_0  = 8'hEE;
    bus.reg_data_1  = 8'h20;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'h9C, 8'h22, 8'h00, 8'h20);
    chk("mem retained", bus.reg_w_data, 8'h11);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
